// File: rtl/dut_sequencer_pkg.sv
// Shared types and default constants for the DUT Reset/Start/Ack program sequencer.
package dut_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_STRT,
        ST_RUN,
        ST_RPT
    } seq_state_t;

    localparam int unsigned DEF_PW        = 2;
    localparam int unsigned DEF_CW        = 16;
    localparam int unsigned DEF_RST_CYC   = 2;
    localparam int unsigned DEF_START_CYC = 1;
    localparam int unsigned DEF_TIMEOUT   = 32'h0000_FFFF;

endpackage

// File: rtl/dut_sequencer_timer.sv
// Loadable up/down counter with a terminal-match flag, shared by the RST, STRT and RUN phases.
module seq_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic         up,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] count,
    output logic         term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (step) begin
            count <= up ? count + W'(1) : count - W'(1);
        end
    end

    assign term = (count == term_val);

endmodule

// File: rtl/dut_sequencer.sv
// Drives the DUT Reset/Start/Ack handshake for programs 0..NumProgs-1 and reports run cycles.
module dut_sequencer
    import dut_sequencer_pkg::*;
#(
    parameter int unsigned PW        = DEF_PW,
    parameter int unsigned CW        = DEF_CW,
    parameter int unsigned RST_CYC   = DEF_RST_CYC,
    parameter int unsigned START_CYC = DEF_START_CYC,
    parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Go,
    input  logic [PW-1:0] NumProgs,
    input  logic          Ack,
    output logic          DutReset,
    output logic          DutStart,
    output logic [PW-1:0] ProgSel,
    output logic [CW-1:0] CycleCt,
    output logic          CycleValid,
    output logic          Busy,
    output logic          Done,
    output logic          Timeout
);

    seq_state_t    state, state_d;
    logic [PW-1:0] num_q, num_d, sel_d;
    logic [CW-1:0] ct_d;
    logic          valid_d, busy_d, done_d, to_d, rst_d, start_d;

    logic          t_load, t_step, t_up, t_hit;
    logic [CW-1:0] t_val, t_term, t_count;

    // RST/STRT count down to 1; RUN counts up from 1 towards TIMEOUT.
    seq_timer #(.W(CW)) u_timer (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .load     (t_load),
        .load_val (t_val),
        .step     (t_step),
        .up       (t_up),
        .term_val (t_term),
        .count    (t_count),
        .term     (t_hit)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            num_q      <= '0;
            ProgSel    <= '0;
            CycleCt    <= '0;
            CycleValid <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            DutReset   <= 1'b1;
            DutStart   <= 1'b0;
        end else begin
            state      <= state_d;
            num_q      <= num_d;
            ProgSel    <= sel_d;
            CycleCt    <= ct_d;
            CycleValid <= valid_d;
            Busy       <= busy_d;
            Done       <= done_d;
            Timeout    <= to_d;
            DutReset   <= rst_d;
            DutStart   <= start_d;
        end
    end

    always_comb begin
        state_d = state;
        num_d   = num_q;
        sel_d   = ProgSel;
        ct_d    = CycleCt;
        valid_d = 1'b0;
        busy_d  = Busy;
        done_d  = Done;
        to_d    = Timeout;
        rst_d   = DutReset;
        start_d = DutStart;
        t_load  = 1'b0;
        t_step  = 1'b0;
        t_val   = '0;
        t_up    = (state == ST_RUN);
        t_term  = (state == ST_RUN) ? CW'(TIMEOUT) : CW'(1);

        case (state)
            ST_IDLE: begin
                if (Go) begin
                    num_d = NumProgs;
                    sel_d = '0;
                    to_d  = 1'b0;
                    if (NumProgs == '0) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        rst_d   = 1'b1;
                        start_d = 1'b0;
                        t_load  = 1'b1;
                        t_val   = CW'(RST_CYC);
                        state_d = ST_RST;
                    end
                end
            end
            ST_RST: begin
                if (t_hit) begin
                    rst_d   = 1'b0;
                    start_d = 1'b1;
                    t_load  = 1'b1;
                    t_val   = CW'(START_CYC);
                    state_d = ST_STRT;
                end else begin
                    t_step = 1'b1;
                end
            end
            ST_STRT: begin
                if (t_hit) begin
                    start_d = 1'b0;
                    t_load  = 1'b1;
                    t_val   = CW'(1);
                    state_d = ST_RUN;
                end else begin
                    t_step = 1'b1;
                end
            end
            ST_RUN: begin
                // Ack takes priority over a coincident timeout.
                if (Ack) begin
                    ct_d    = t_count;
                    valid_d = 1'b1;
                    state_d = ST_RPT;
                end else if (t_hit) begin
                    ct_d    = CW'(TIMEOUT);
                    to_d    = 1'b1;
                    valid_d = 1'b1;
                    state_d = ST_RPT;
                end else begin
                    t_step = 1'b1;
                end
            end
            ST_RPT: begin
                if (Timeout || (ProgSel == num_q - PW'(1))) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rst_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    sel_d   = ProgSel + PW'(1);
                    rst_d   = 1'b1;
                    t_load  = 1'b1;
                    t_val   = CW'(RST_CYC);
                    state_d = ST_RST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dut_sequencer.sv
// Self-checking bench for dut_sequencer: a behavioural DUT (Ack generator) plus a per-sequence outcome model.
module tb_dut_sequencer;

    localparam int unsigned PW = 2;
    localparam int unsigned CW = 16;
    localparam int R = 2;
    localparam int S = 1;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          ack = 1'b0;
    logic [PW-1:0] num_progs = '0;
    logic          DutReset, DutStart, CycleValid, Busy, Done, Timeout;
    logic [PW-1:0] ProgSel;
    logic [CW-1:0] CycleCt;

    dut_sequencer #(
        .PW(PW), .CW(CW), .RST_CYC(R), .START_CYC(S), .TIMEOUT(T)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .Go(go), .NumProgs(num_progs), .Ack(ack),
        .DutReset(DutReset), .DutStart(DutStart), .ProgSel(ProgSel), .CycleCt(CycleCt),
        .CycleValid(CycleValid), .Busy(Busy), .Done(Done), .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int prog;
        int ct;
        int to;
    } exp_t;
    exp_t exp_q[$];

    // Processor model: Ack rises on the k-th cycle after Start falls, cleared by DUT reset.
    int   ack_delay[4];
    bit   stale = 1'b0;
    int   run_idx = -1;
    int   run_cnt = 0;
    bit   in_run = 1'b0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_run = 1'b0;
            ack = 1'b0;
        end else begin
            if (prev_start && !DutStart) begin
                run_idx = run_idx + 1;
                run_cnt = 1;
                in_run  = 1'b1;
            end else if (in_run) begin
                run_cnt = run_cnt + 1;
            end
            if (DutReset || DutStart) in_run = 1'b0;
            if (stale) ack = 1'b1;
            else ack = in_run && (run_idx >= 0) && (run_idx < 4) && (run_cnt >= ack_delay[run_idx]);
        end
        prev_start = DutStart;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Outcome of a whole sequence from the handshake rules alone.
    task automatic model(input int n, output int total, output int nexec, output int any_to);
        int k;
        int tof;
        total  = 1;
        nexec  = 0;
        any_to = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            tof = 0;
            if (stale) k = 1;
            else if (ack_delay[i] <= T) k = ack_delay[i];
            else begin k = T; tof = 1; end
            exp_q.push_back('{prog: i, ct: k, to: tof});
            total += R + S + k + 1;
            nexec++;
            if (tof != 0) begin any_to = 1; break; end
        end
    endtask

    task automatic run_seq(input int n, input bit go_in_run);
        int total, nexec, any_to;
        int nstrobe = 0, first_start = 0, start_cyc = 0, rst_rep = 0, done_at = 0, busy_bad = 0;
        exp_t e;
        model(n, total, nexec, any_to);
        @(negedge clk);
        run_idx   = -1;
        num_progs = PW'(n);
        go        = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("accept_busy", 32'(n != 0), 32'(Busy));
        check("accept_done", 32'(Done), 32'(n == 0));
        check("accept_timeout", 32'(Timeout), 32'd0);
        for (int s = 1; s <= 400; s++) begin
            if (CycleValid) begin
                nstrobe++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("prog_sel", 32'(ProgSel), e.prog);
                    check("cycle_ct", 32'(CycleCt), e.ct);
                    check("timeout_rpt", 32'(Timeout), e.to);
                end else begin
                    check("strobe_overrun", nstrobe, nexec);
                end
            end
            if (DutStart) begin
                start_cyc++;
                if (first_start == 0) first_start = s;
            end
            if (DutReset && first_start != 0) rst_rep++;
            if (!Done && !Busy) busy_bad++;
            if (go_in_run && first_start != 0 && s == first_start + S + 1) begin
                go = 1'b1;
                num_progs = '0;
            end else begin
                go = 1'b0;
            end
            if (Done) begin
                done_at = s;
                break;
            end
            @(negedge clk);
        end
        go = 1'b0;
        check("done_cycle", done_at, total);
        check("strobe_count", nstrobe, nexec);
        check("start_cycles", start_cyc, nexec * S);
        check("first_start", first_start, (n == 0) ? 0 : R + 1);
        check("reset_repulse", rst_rep, (nexec == 0) ? 0 : (nexec - 1) * R);
        check("busy_gap", busy_bad, 0);
        check("end_busy", 32'(Busy), 32'd0);
        check("end_timeout", 32'(Timeout), any_to);
        if (n != 0) begin
            check("end_dut_reset", 32'(DutReset), 32'd0);
            check("end_dut_start", 32'(DutStart), 32'd0);
            check("end_prog_sel", 32'(ProgSel), nexec - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        int strobes;
        repeat (3) @(negedge clk);
        check("rst_in_dut_reset", 32'(DutReset), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dut_reset", 32'(DutReset), 32'd1);
        check("rst_dut_start", 32'(DutStart), 32'd0);
        check("rst_prog_sel", 32'(ProgSel), 32'd0);
        check("rst_cycle_ct", 32'(CycleCt), 32'd0);
        check("rst_valid", 32'(CycleValid), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_timeout", 32'(Timeout), 32'd0);

        ack_delay = '{5, 5, 5, 5};
        run_seq(0, 1'b0);
        check("zero_holds_reset", 32'(DutReset), 32'd1);

        ack_delay = '{5, 100, 100, 100};
        run_seq(1, 1'b0);

        ack_delay = '{4, 7, 2, 100};
        run_seq(3, 1'b0);

        ack_delay = '{100, 100, 100, 100};
        run_seq(3, 1'b0);

        ack_delay = '{8, 100, 100, 100};
        run_seq(1, 1'b0);

        stale = 1'b1;
        run_seq(2, 1'b0);
        stale = 1'b0;

        ack_delay = '{3, 6, 100, 100};
        run_seq(2, 1'b1);

        for (int i = 0; i < 12; i++) begin
            n = int'($urandom_range(0, 3));
            for (int j = 0; j < 4; j++) ack_delay[j] = int'($urandom_range(1, 10));
            stale = ($urandom_range(0, 5) == 0);
            run_seq(n, ($urandom_range(0, 3) == 0));
        end
        stale = 1'b0;

        // Asynchronous abort in the middle of RUN.
        ack_delay = '{100, 100, 100, 100};
        @(negedge clk);
        run_idx = -1;
        num_progs = PW'(3);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int s = 0; s < 20 && !DutStart; s++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("abort_pre_busy", 32'(Busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_dut_reset", 32'(DutReset), 32'd1);
        check("abort_dut_start", 32'(DutStart), 32'd0);
        check("abort_prog_sel", 32'(ProgSel), 32'd0);
        check("abort_cycle_ct", 32'(CycleCt), 32'd0);
        check("abort_valid", 32'(CycleValid), 32'd0);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_timeout", 32'(Timeout), 32'd0);
        strobes = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            if (CycleValid) strobes++;
        end
        check("abort_no_strobe", strobes, 0);
        check("abort_idle_busy", 32'(Busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dut_sequencer.md
Name: dut_sequencer

Overview:
- Host-side controller driving the processor's Reset/Start/Ack program handshake from the initiator end.
- Runs programs 0..NumProgs-1 back to back. Per program: holds the DUT in reset, pulses Start, waits for the Ack done flag, measures run cycles, then reports the count.
- Sits in the test harness / FPGA wrapper above the processor top level, replacing bench-driven Reset/Start sequencing.

Parameters:
- PW, 2, width of program index / NumProgs.
- CW, 16, width of the cycle counter.
- RST_CYC, 2, cycles DutReset is held high per program (>=1).
- START_CYC, 1, cycles DutStart is held high per program (>=1).
- TIMEOUT, 16'hFFFF, max RUN cycles before abort (<= 2**CW-1).

Ports:
- Clk  in  1  clock; all logic on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- Go  in  1  launch request; sampled only in IDLE.
- NumProgs  in  PW  number of programs to run; latched on accepted Go.
- Ack  in  1  DUT done flag.
- DutReset  out  1  active-high reset to DUT.
- DutStart  out  1  Start to DUT.
- ProgSel  out  PW  current program index to DUT / ROM bank select.
- CycleCt  out  CW  RUN-cycle count of the last finished program.
- CycleValid  out  1  one-cycle strobe: CycleCt/ProgSel valid.
- Busy  out  1  high from accepted Go until return to IDLE.
- Done  out  1  sequence complete; level, cleared by next accepted Go.
- Timeout  out  1  sticky; a program hit TIMEOUT; cleared by next accepted Go.

Behaviour:
- Reset_n low (async): state IDLE.
  - DutReset=1 (DUT held in reset).
  - DutStart=0, ProgSel=0, CycleCt=0, CycleValid=0, Busy=0, Done=0, Timeout=0, internal counters=0.
- Reset_n mid-sequence: immediate abort to the values above; no CycleValid emitted.
- States: IDLE, RST, STRT, RUN, RPT. All outputs registered.
- IDLE:
  - DutReset holds its last value (1 after reset, 0 after a completed sequence).
  - Go=1: latch NumProgs, ProgSel=0, Done=0, Timeout=0, Busy=1.
  - If latched NumProgs=0: Done=1, Busy=0, stay IDLE.
  - Otherwise go to RST.
  - Go is ignored in all other states.
- RST: DutReset=1, DutStart=0 for exactly RST_CYC cycles, then STRT.
- STRT: DutReset=0, DutStart=1 for exactly START_CYC cycles, then RUN. Ack is ignored in STRT (stale Ack from a previous run is not a completion).
- RUN:
  - DutStart=0; run counter = 1 in the first RUN cycle, +1 each cycle.
  - Ack sampled 1: CycleCt <= run counter, go to RPT.
  - Else, run counter == TIMEOUT: Timeout=1, CycleCt <= TIMEOUT, go to RPT.
  - Ack and TIMEOUT in the same cycle: Ack wins, Timeout stays 0.
- RPT: CycleValid=1 for exactly one cycle; ProgSel = finished program.
  - Next cycle, if Timeout=1 or ProgSel == NumProgs-1: IDLE, Done=1, Busy=0, DutReset=0 (DUT left idle, not reset).
  - Else ProgSel <= ProgSel+1, go to RST.
- CycleCt holds until the next RPT or reset.
- Latency: Go accepted -> DutStart rise = RST_CYC+1 cycles. Ack=1 -> CycleValid = 1 cycle.
- Total sequence with Ack after k RUN cycles per program = 1 + NumProgs*(RST_CYC+START_CYC+k+1) cycles to Done.
- ProgSel never wraps: NumProgs = 2**PW-1 is the maximum; NumProgs is PW bits.

Decomposition:
- Shared package: state enum type (IDLE/RST/STRT/RUN/RPT) and default parameter constants.
- Natural sub-module: seq_timer, a loadable down/up counter with terminal flag. It is reused for the RST_CYC, START_CYC and RUN/TIMEOUT counts. Remaining FSM and registers live in dut_sequencer.

Test Plan:
- Reset behaviour: Reset_n=0 for 3 cycles, then 1 -> DutReset=1, all other outputs 0, state IDLE. Assert Reset_n=0 during RUN -> same values immediately (async); no CycleValid.
- Single program: NumProgs=1, Go pulse, DUT model raises Ack 5 cycles into RUN -> DutReset high 2 cycles, DutStart high 1 cycle, CycleValid once with CycleCt=5, ProgSel=0; Done=1, Busy=0 one cycle later.
- Multi-program: NumProgs=3, Ack delays 4/7/2 -> three CycleValid strobes with (ProgSel,CycleCt) = (0,4), (1,7), (2,2); DutReset re-pulses between programs; Done=1 after the third.
- Timeout: TIMEOUT=8, Ack never rises -> CycleValid with CycleCt=8, Timeout=1, Done=1, remaining programs skipped. Ack at run counter 8 instead -> Timeout=0, CycleCt=8.
- Stale Ack and Go filtering: Ack held 1 during RST/STRT -> ignored, CycleCt reflects the first RUN-cycle Ack (=1). Go pulsed during RUN -> no effect.
- Zero programs: NumProgs=0 with Go -> DutStart never asserts, Done=1 the next cycle, CycleValid never strobes.
